// File: rtl/sdram_stream_writer.sv
// sdram_stream_writer
// Accepts a 16-bit sample stream and writes it as consecutive words to an
// Avalon-MM SDRAM controller slave, starting at a programmable word address.
// Samples are staged in a small registered FIFO so the stream side and the
// memory side can stall independently.
//
// Optional feature: define SDRAM_STREAM_WRITER_TIMEOUT_EN to add a stall
// watchdog. After 255 consecutive stalled write cycles the transfer is
// abandoned and err is raised. Without the macro, err is tied low and the
// ERR state is never entered.

module sdram_stream_writer #(
  parameter int ADDR_W     = 25,
  parameter int CNT_W      = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset,

  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              err,

  input  logic [15:0]       snk_data,
  input  logic              snk_valid,
  output logic              snk_ready,

  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [15:0]       avm_writedata,
  output logic [1:0]        avm_byteenable,
  input  logic              avm_waitrequest
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Transfer bookkeeping
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  wc_q;
  logic [CNT_W-1:0]  acc_cnt;
  logic [CNT_W-1:0]  wr_cnt;

  // FIFO storage and pointers
  logic [15:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    level;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic flush;
  logic start_ok;
  logic timeout;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == FULL_LVL);
  assign start_ok   = (state == IDLE) && start;

  assign snk_ready  = (state == RUN) && !fifo_full && (acc_cnt != wc_q);
  assign push       = snk_valid && snk_ready;

  assign avm_write      = (state == RUN) && !fifo_empty;
  assign pop            = avm_write && !avm_waitrequest;
  assign avm_address    = addr_q;
  // Head is forced to zero when empty so the bus never shows stale or
  // uninitialised storage while idle.
  assign avm_writedata  = fifo_empty ? '0 : mem[rd_ptr];
  assign avm_byteenable = 2'b11;

  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  // Pending samples are thrown away when the watchdog abandons a transfer.
  assign flush = (state == RUN) && (state_nxt == ERR);

`ifdef SDRAM_STREAM_WRITER_TIMEOUT_EN
  logic [7:0] stall_cnt;
  logic       stall;
  logic       err_q;

  assign stall = avm_write && avm_waitrequest;
  // The counter reaches 255 on the same edge that moves the FSM to ERR.
  assign timeout = stall && (stall_cnt == 8'd254);
  assign err     = err_q;

  // Consecutive-stall counter, cleared by any non-stalled cycle
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 8'd1;
    end else begin
      stall_cnt <= '0;
    end
  end

  // Sticky error flag, cleared only by the next accepted start
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      err_q <= 1'b0;
    end else if (start_ok) begin
      err_q <= 1'b0;
    end else if (flush) begin
      err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (word_count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (timeout) begin
          state_nxt = ERR;
        end else if (pop && (wr_cnt == (wc_q - 1'b1))) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address and word counters; parameters captured on an accepted start
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      addr_q  <= '0;
      wc_q    <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
    end else if (start_ok) begin
      addr_q  <= base_addr;
      wc_q    <= word_count;
      acc_cnt <= '0;
      wr_cnt  <= '0;
    end else begin
      if (push) begin
        acc_cnt <= acc_cnt + 1'b1;
      end
      if (pop) begin
        wr_cnt <= wr_cnt + 1'b1;
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy; push and pop may coincide at any level
  always_ff @(posedge clk_clk) begin
    if (reset_reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (!push && pop) begin
        level <= level - 1'b1;
      end
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk_clk) begin
    if (push) begin
      mem[wr_ptr] <= snk_data;
    end
  end

endmodule

// File: tb/tb_sdram_stream_writer.sv
// tb_sdram_stream_writer
// Directed bench for sdram_stream_writer. Accepted samples are pushed to a
// scoreboard with the address they should land at; completed writes pop and
// compare. Define SDRAM_STREAM_WRITER_TIMEOUT_EN to exercise the watchdog.

module tb_sdram_stream_writer;

  localparam int ADDR_W     = 25;
  localparam int CNT_W      = 24;
  localparam int FIFO_DEPTH = 8;

  logic              clk = 1'b0;
  logic              reset_reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic              busy, done, err;
  logic [15:0]       snk_data = '0;
  logic              snk_valid = 1'b0;
  logic              snk_ready;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic [15:0]       avm_writedata;
  logic [1:0]        avm_byteenable;
  logic              avm_waitrequest = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [15:0]       exp_data_q[$];

  always #5 clk = ~clk;

  sdram_stream_writer #(
    .ADDR_W(ADDR_W),
    .CNT_W(CNT_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_clk(clk),
    .reset_reset(reset_reset),
    .start(start),
    .base_addr(base_addr),
    .word_count(word_count),
    .busy(busy),
    .done(done),
    .err(err),
    .snk_data(snk_data),
    .snk_valid(snk_valid),
    .snk_ready(snk_ready),
    .avm_address(avm_address),
    .avm_write(avm_write),
    .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_snk_ready"}, 32'(snk_ready), 0);
    check({tag, "_avm_write"}, 32'(avm_write), 0);
    check({tag, "_avm_address"}, 32'(avm_address), 0);
    check({tag, "_avm_writedata"}, 32'(avm_writedata), 0);
  endtask

  // mode 0: no waitrequest; mode 1: waitrequest high 3 of every 4 cycles.
  // abort_after > 0: pulse reset once that many words have been written.
  task automatic run_xfer(input logic [ADDR_W-1:0] base, input int count,
                          input int mode, input int abort_after);
    logic [ADDR_W-1:0] model_addr;
    logic [ADDR_W-1:0] ea;
    logic [ADDR_W-1:0] prev_addr;
    logic [15:0]       ed;
    logic [15:0]       prev_data;
    logic [15:0]       sample;
    int  sent = 0;
    int  written = 0;
    int  occ = 0;
    int  cycles = 0;
    int  first_acc = -1;
    int  first_wr = -1;
    int  last_wr = -1;
    bit  prev_stall = 0;
    bit  saw_full = 0;
    bit  finished = 0;
    bit  aborted = 0;
    bit  pushed;

    exp_addr_q.delete();
    exp_data_q.delete();
    model_addr = base;

    @(posedge clk); #1;
    start = 1'b1; base_addr = base; word_count = CNT_W'(count);
    snk_valid = 1'b0; avm_waitrequest = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;

    while (!finished && cycles < 400) begin
      sample = 16'(32'hA001 + 32'(sent) + 32'(base[7:0]));
      snk_valid = (sent < count);
      snk_data = sample;
      avm_waitrequest = (mode == 1) ? ((cycles % 4) != 3) : 1'b0;
      // A stray start mid-transfer with different parameters must be ignored.
      if (mode == 1 && cycles == 5) begin
        start = 1'b1; base_addr = '0; word_count = CNT_W'(1);
      end else begin
        start = 1'b0;
      end

      @(negedge clk);
      if (done) begin
        check("done_timing", 32'(cycles), 32'(last_wr + 1));
        check("done_busy_low", 32'(busy), 0);
        check("words_written", 32'(written), 32'(count));
        check("scoreboard_empty", 32'(exp_addr_q.size()), 0);
        finished = 1;
      end else begin
        check("busy_high", 32'(busy), 1);
        check("err_low", 32'(err), 0);
        check("snk_ready", 32'(snk_ready), 32'((occ < FIFO_DEPTH) && (sent < count)));
        if (occ == FIFO_DEPTH && !snk_ready) saw_full = 1;
        if (prev_stall) begin
          check("stall_hold_write", 32'(avm_write), 1);
          check("stall_hold_addr", 32'(avm_address), 32'(prev_addr));
          check("stall_hold_data", 32'(avm_writedata), 32'(prev_data));
        end
        if (avm_write && !avm_waitrequest) begin
          if (exp_addr_q.size() == 0) begin
            check("unexpected_write", 32'(avm_write), 0);
          end else begin
            ea = exp_addr_q.pop_front();
            ed = exp_data_q.pop_front();
            check("wr_addr", 32'(avm_address), 32'(ea));
            check("wr_data", 32'(avm_writedata), 32'(ed));
          end
          written++;
          occ--;
          if (first_wr < 0) first_wr = cycles;
          last_wr = cycles;
        end
        pushed = snk_valid && snk_ready;
        if (pushed) begin
          exp_addr_q.push_back(model_addr);
          exp_data_q.push_back(sample);
          model_addr = model_addr + 1'b1;
          sent++;
          occ++;
          if (first_acc < 0) first_acc = cycles;
        end
        prev_stall = avm_write && avm_waitrequest;
        prev_addr = avm_address;
        prev_data = avm_writedata;
      end

      if (!finished && abort_after > 0 && written == abort_after) begin
        @(posedge clk); #1;
        reset_reset = 1'b1; avm_waitrequest = 1'b1; snk_valid = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        reset_reset = 1'b0; avm_waitrequest = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_no_write", 32'(avm_write), 0);
        check("abort_busy", 32'(busy), 0);
        finished = 1;
        aborted = 1;
      end

      cycles++;
      if (!finished) begin
        @(posedge clk); #1;
      end
    end

    if (!finished) check("xfer_timeout", 32'(finished), 1);

    if (!aborted) begin
      if (mode == 0) begin
        check("first_write_latency", 32'(first_wr - first_acc), 1);
        check("consecutive_writes", 32'(last_wr - first_wr), 32'(count - 1));
      end
      if (mode == 1) check("ready_dropped_full", 32'(saw_full), 1);
      @(posedge clk); #1;
      snk_valid = 1'b0; avm_waitrequest = 1'b0; start = 1'b0;
      @(negedge clk);
      check("done_one_cycle", 32'(done), 0);
      check("idle_busy", 32'(busy), 0);
    end
    snk_valid = 1'b0;
  endtask

  initial begin
    int stalled;
    bit seen;
    bit accepted;

    // Reset state
    repeat (3) @(posedge clk);
    snk_valid = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    check("byteenable", 32'(avm_byteenable), 32'h3);
    @(posedge clk); #1;
    reset_reset = 1'b0; snk_valid = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(snk_ready), 0);

    // Back-to-back, no stalls
    run_xfer(25'h100, 4, 0, 0);
    // Heavy stalls, FIFO fills, stray start ignored
    run_xfer(25'h200, 20, 1, 0);
    // Address wrap
    run_xfer(25'h1FFFFFE, 4, 0, 0);

    // Zero-length transfer
    @(posedge clk); #1;
    start = 1'b1; base_addr = 25'h55; word_count = '0;
    @(negedge clk);
    check("zero_start_busy", 32'(busy), 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_done", 32'(done), 1);
    check("zero_busy", 32'(busy), 0);
    check("zero_write", 32'(avm_write), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("zero_done_once", 32'(done), 0);
    check("zero_busy_after", 32'(busy), 0);

    // Reset mid-transfer, then a short normal transfer
    run_xfer(25'h300, 10, 0, 3);
    run_xfer(25'h400, 2, 0, 0);

    // Stalled write held for a long time
    @(posedge clk); #1;
    start = 1'b1; base_addr = 25'h40; word_count = CNT_W'(1);
    snk_valid = 1'b0; avm_waitrequest = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; snk_valid = 1'b1; snk_data = 16'hBEEF;
    stalled = 0;
    seen = 0;
`ifdef SDRAM_STREAM_WRITER_TIMEOUT_EN
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      accepted = snk_valid && snk_ready;
      if (err) begin
        seen = 1;
        check("timeout_stall_cycles", 32'(stalled), 255);
        check("timeout_write_low", 32'(avm_write), 0);
        check("timeout_busy_low", 32'(busy), 0);
        check("timeout_done_low", 32'(done), 0);
      end else if (avm_write && avm_waitrequest) begin
        stalled++;
      end
      @(posedge clk); #1;
      if (accepted) snk_valid = 1'b0;
    end
    check("timeout_err_seen", 32'(seen), 1);
    @(negedge clk);
    check("err_sticky", 32'(err), 1);
    check("err_idle_write", 32'(avm_write), 0);
    check("err_idle_busy", 32'(busy), 0);
    @(posedge clk); #1;
    avm_waitrequest = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 25'h80; word_count = CNT_W'(1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("err_cleared", 32'(err), 0);
    // Leftover sample must have been flushed: next transfer writes fresh data.
    run_xfer(25'h90, 2, 0, 0);
`else
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      accepted = snk_valid && snk_ready;
      if (avm_write && avm_waitrequest) stalled++;
      if (err) seen = 1;
      @(posedge clk); #1;
      if (accepted) snk_valid = 1'b0;
    end
    check("hold_stalled_cycles", 32'(stalled), 299);
    check("hold_no_err", 32'(seen), 0);
    avm_waitrequest = 1'b0;
    @(negedge clk);
    check("hold_write", 32'(avm_write), 1);
    check("hold_addr", 32'(avm_address), 32'h40);
    check("hold_data", 32'(avm_writedata), 32'hBEEF);
    @(posedge clk); #1;
    @(negedge clk);
    check("hold_done", 32'(done), 1);
    check("hold_err", 32'(err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    n_fail++;
    $display("FAIL global_timeout: observed running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/sdram_stream_writer.md
SDRAM_STREAM_WRITER -- requirements
Module: sdram_stream_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, SDRAM word-address width (matches 13 row + 10 col + 2 bank).
REQ-002 SHALL have parameter CNT_W, default 24, transfer-length counter width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, internal buffer depth in 16-bit words (power of two, >= 2).
REQ-004 clk_clk  in  1  sole clock, all logic rising-edge.
REQ-005 reset_reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle pulse, begins a transfer when idle.
REQ-007 base_addr  in  ADDR_W  first SDRAM word address, sampled on accepted start.
REQ-008 word_count  in  CNT_W  number of 16-bit words to transfer, sampled on accepted start.
REQ-009 busy  out  1  high from accepted start until done/error.
REQ-010 done  out  1  one-cycle pulse at transfer completion.
REQ-011 err  out  1  sticky timeout flag, cleared by next accepted start.
REQ-012 snk_data  in  16  stream sample.
REQ-013 snk_valid  in  1  stream sample valid.
REQ-014 snk_ready  out  1  block accepts sample this cycle.
REQ-015 avm_address  out  ADDR_W  word address to SDRAM controller slave.
REQ-016 avm_write  out  1  write request.
REQ-017 avm_writedata  out  16  write data.
REQ-018 avm_byteenable  out  2  always 2'b11.
REQ-019 avm_waitrequest  in  1  slave stall.

Function
REQ-020 FSM states SHALL be IDLE, RUN, DONE, ERR; IDLE->RUN on start with word_count!=0; IDLE->DONE on start with word_count==0 (no writes issued).
REQ-021 start while not IDLE SHALL be ignored with no effect on counters or outputs.
REQ-022 Sample transfer SHALL occur when snk_valid && snk_ready; snk_ready = (state==RUN) && !fifo_full && accepted_cnt<word_count.
REQ-023 avm_write SHALL be high whenever state==RUN and FIFO non-empty; avm_writedata = FIFO head; avm_address = base_addr + written_cnt modulo 2^ADDR_W (wraps silently).
REQ-024 While avm_write && avm_waitrequest, avm_address/avm_writedata/avm_write SHALL hold stable.
REQ-025 Write completes when avm_write && !avm_waitrequest; FIFO pops and written_cnt increments that cycle.
REQ-026 Simultaneous push and pop SHALL be legal in the same cycle, including at FIFO_DEPTH-1 occupancy; occupancy unchanged.
REQ-027 Minimum latency: sample accepted in cycle N appears on avm_write in cycle N+1 (FIFO registered).
REQ-028 RUN->DONE in the cycle after written_cnt reaches word_count; DONE asserts done for exactly one cycle then returns to IDLE; busy low in DONE.
REQ-029 Sustained throughput SHALL be one word per cycle with no waitrequest and continuous snk_valid.

Reset
REQ-030 On reset_reset: state=IDLE, FIFO empty, counters 0, busy=0, done=0, err=0, snk_ready=0, avm_write=0, avm_address=0, avm_writedata=0.
REQ-031 Reset asserted mid-transfer SHALL abort immediately; pending FIFO contents discarded, no further writes issued.

Configuration
REQ-032 Macro SDRAM_STREAM_WRITER_TIMEOUT_EN SHALL, when defined, add an 8-bit stall counter counting consecutive avm_write&&avm_waitrequest cycles, cleared on any other cycle.
REQ-033 With macro defined, counter reaching 255 SHALL force RUN->ERR: avm_write drops next cycle, FIFO flushed, err=1, busy=0; ERR->IDLE next cycle, err held until next accepted start.
REQ-034 Without macro, ERR state unreachable, err tied 0, no stall counter synthesized.

Verification
REQ-035 base_addr=0x100, word_count=4, samples 0xA001..0xA004 back-to-back, waitrequest=0 -> writes to 0x100..0x103 with matching data on 4 consecutive cycles, done pulse 1 cycle after last write.
REQ-036 word_count=20, waitrequest high 3 of every 4 cycles -> snk_ready drops when 8 words buffered, address/data stable during stalls, all 20 words written in order.
REQ-037 base_addr=0x1FFFFFE, word_count=4 -> addresses 0x1FFFFFE, 0x1FFFFFF, 0x0000000, 0x0000001.
REQ-038 start with word_count=0 -> no avm_write, done high exactly one cycle later, busy never high.
REQ-039 reset_reset pulsed after 3 of 10 words written -> avm_write low next cycle, all outputs at reset values; subsequent start of 2 words completes normally.
REQ-040 With SDRAM_STREAM_WRITER_TIMEOUT_EN, waitrequest held high 300 cycles -> err=1 and avm_write=0 after 255 stalled cycles; next start clears err.
